line_raster: RTL and testbench



---
 rtl/line_raster.sv | 162 ++++++++++++++++
 tb/tb_line_raster.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_raster.sv
// line_raster: Bresenham rasterizer turning one line command into per-pixel framebuffer write requests.
// Latency: first pixel valid 2 cycles after command accept, then one pixel per cycle; done pulse after last consume.
// Backpressure: a visible pixel holds valid/addr/data until I_PIX_READY; off-screen pixels drain silently in one cycle.
module line_raster #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        I_CLK,
    input  logic        I_RST_N,
    input  logic        I_CMD_VALID,
    output logic        O_CMD_READY,
    input  logic [9:0]  I_X0,
    input  logic [9:0]  I_Y0,
    input  logic [9:0]  I_X1,
    input  logic [9:0]  I_Y1,
    input  logic [15:0] I_COLOR,
    output logic        O_PIX_VALID,
    input  logic        I_PIX_READY,
    output logic [17:0] O_PIX_ADDR,
    output logic [15:0] O_PIX_DATA,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;

    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);
    localparam logic [17:0] PITCH = 18'(H_RES);

    state_t             state;
    // (x, y) is the next pixel to be loaded into the output slot; x1/y1 is the end point
    logic [9:0]         x;
    logic [9:0]         y;
    logic [9:0]         x1;
    logic [9:0]         y1;
    logic [15:0]        color;
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic signed [12:0] err;
    logic               sx_inc;
    logic               sy_inc;
    // Output slot: holds the pixel currently presented downstream (visible or not)
    logic               slot_full;
    logic               slot_vis;
    logic               slot_last;

    logic [9:0]         adx;
    logic [9:0]         ady;
    logic signed [12:0] e2;
    logic signed [12:0] err_next;
    logic               step_x;
    logic               step_y;
    logic [9:0]         x_next;
    logic [9:0]         y_next;
    logic               at_end;
    logic               cur_vis;
    logic [17:0]        cur_addr;
    logic               consume;
    logic               load;

    // Bresenham step, visibility/address of the next pixel, and slot handshake decode
    always_comb begin
        adx      = (x1 >= x) ? (x1 - x) : (x - x1);
        ady      = (y1 >= y) ? (y1 - y) : (y - y1);
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err + (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);
        x_next   = step_x ? (sx_inc ? x + 10'd1 : x - 10'd1) : x;
        y_next   = step_y ? (sy_inc ? y + 10'd1 : y - 10'd1) : y;
        at_end   = (x == x1) && (y == y1);
        cur_vis  = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
        cur_addr = ({8'd0, y} * PITCH) + {8'd0, x};
        // An off-screen pixel in the slot needs no handshake and leaves after one cycle
        consume  = slot_full && (!slot_vis || I_PIX_READY);
        // Refill the slot when it is empty or draining, unless it holds the end point
        load     = (state == DRAW) && !(slot_full && slot_last) && (!slot_full || consume);
    end

    // Control FSM with registered outputs; coordinate/error state advances as pixels are loaded
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state       <= IDLE;
            x           <= 10'd0;
            y           <= 10'd0;
            x1          <= 10'd0;
            y1          <= 10'd0;
            color       <= 16'd0;
            dx          <= 13'sd0;
            dy          <= 13'sd0;
            err         <= 13'sd0;
            sx_inc      <= 1'b0;
            sy_inc      <= 1'b0;
            slot_full   <= 1'b0;
            slot_vis    <= 1'b0;
            slot_last   <= 1'b0;
            O_CMD_READY <= 1'b1;
            O_PIX_VALID <= 1'b0;
            O_PIX_ADDR  <= 18'd0;
            O_PIX_DATA  <= 16'd0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_CMD_VALID && O_CMD_READY) begin
                        x           <= I_X0;
                        y           <= I_Y0;
                        x1          <= I_X1;
                        y1          <= I_Y1;
                        color       <= I_COLOR;
                        O_CMD_READY <= 1'b0;
                        O_BUSY      <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    // x/y still hold the start point here
                    dx        <= $signed({3'b000, adx});
                    dy        <= -$signed({3'b000, ady});
                    err       <= $signed({3'b000, adx}) - $signed({3'b000, ady});
                    sx_inc    <= (x < x1);
                    sy_inc    <= (y < y1);
                    slot_full <= 1'b0;
                    slot_last <= 1'b0;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (load) begin
                        slot_full   <= 1'b1;
                        slot_vis    <= cur_vis;
                        slot_last   <= at_end;
                        O_PIX_VALID <= cur_vis;
                        O_PIX_ADDR  <= cur_addr;
                        O_PIX_DATA  <= color;
                        if (!at_end) begin
                            x   <= x_next;
                            y   <= y_next;
                            err <= err_next;
                        end
                    end else if (consume) begin
                        // Only the end-point pixel drains without a refill
                        slot_full   <= 1'b0;
                        O_PIX_VALID <= 1'b0;
                        O_DONE      <= 1'b1;
                        state       <= FINISH;
                    end
                end
                FINISH: begin
                    O_DONE      <= 1'b0;
                    O_BUSY      <= 1'b0;
                    O_CMD_READY <= 1'b1;
                    slot_last   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// tb_line_raster: directed scenarios for line_raster with a pixel scoreboard.
// Expected pixels (addr, data, cycle seen valid) are queued when a command is issued.
// A negedge monitor pops and compares on every transfer; tasks check done timing and leftovers.
`timescale 1ns/1ps
module tb_line_raster;

    logic        I_CLK = 1'b0;
    logic        I_RST_N = 1'b1;
    logic        I_CMD_VALID = 1'b0;
    logic        O_CMD_READY;
    logic [9:0]  I_X0 = '0;
    logic [9:0]  I_Y0 = '0;
    logic [9:0]  I_X1 = '0;
    logic [9:0]  I_Y1 = '0;
    logic [15:0] I_COLOR = '0;
    logic        O_PIX_VALID;
    logic        I_PIX_READY = 1'b1;
    logic [17:0] O_PIX_ADDR;
    logic [15:0] O_PIX_DATA;
    logic        O_BUSY;
    logic        O_DONE;

    line_raster #(.H_RES(640), .V_RES(480)) dut (
        .I_CLK(I_CLK), .I_RST_N(I_RST_N),
        .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
        .I_X0(I_X0), .I_Y0(I_Y0), .I_X1(I_X1), .I_Y1(I_Y1), .I_COLOR(I_COLOR),
        .O_PIX_VALID(O_PIX_VALID), .I_PIX_READY(I_PIX_READY),
        .O_PIX_ADDR(O_PIX_ADDR), .O_PIX_DATA(O_PIX_DATA),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct { int addr; int data; int cyc; } pix_t;
    pix_t exp_q[$];
    pix_t sb_e;
    int   done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge I_CLK) cyc++;

    // Scoreboard: every transfer pops the oldest expected pixel; done pulses are time-stamped
    always @(negedge I_CLK) begin
        if (O_DONE) done_q.push_back(cyc);
        if (O_PIX_VALID && I_PIX_READY) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got addr %0d at cycle %0d, required no pixel", O_PIX_ADDR, cyc);
            end else begin
                sb_e = exp_q.pop_front();
                if (O_PIX_ADDR !== 18'(sb_e.addr)) begin
                    n_fail++;
                    $display("FAIL pix_addr: got %0d, required %0d", O_PIX_ADDR, sb_e.addr);
                end
                n_checks++;
                if (O_PIX_DATA !== 16'(sb_e.data)) begin
                    n_fail++;
                    $display("FAIL pix_data: got %h, required %h", O_PIX_DATA, 16'(sb_e.data));
                end
                n_checks++;
                if (cyc != sb_e.cyc) begin
                    n_fail++;
                    $display("FAIL pix_cycle (addr %0d): got %0d, required %0d", sb_e.addr, cyc, sb_e.cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin @(posedge I_CLK); #1; end
    endtask

    // Present a command once O_CMD_READY is high; acc is the edge number at which it is accepted
    task automatic send_cmd(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] x1,
                            input logic [9:0] y1, input logic [15:0] col, input bit hold, output int acc);
        int budget = 0;
        while (!O_CMD_READY && budget < 50) begin @(posedge I_CLK); #1; budget++; end
        if (budget >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_ready_timeout: got O_CMD_READY=0 for 50 cycles, required 1");
        end
        I_X0 = x0; I_Y0 = y0; I_X1 = x1; I_Y1 = y1; I_COLOR = col;
        I_CMD_VALID = 1'b1;
        acc = cyc + 1;
        @(posedge I_CLK); #1;
        if (!hold) I_CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(output int d);
        int k = 0;
        while (done_q.size() == 0 && k < 200) begin @(posedge I_CLK); #1; k++; end
        d = (done_q.size() == 0) ? -1 : done_q.pop_front();
    endtask

    task automatic test_reset;
        #2 I_RST_N = 1'b0;
        #3;
        n_checks++; if (O_CMD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", O_CMD_READY); end
        n_checks++; if (O_PIX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b, required 0", O_PIX_VALID); end
        n_checks++; if (O_PIX_ADDR !== 18'd0) begin n_fail++; $display("FAIL reset_pix_addr: got %0d, required 0", O_PIX_ADDR); end
        n_checks++; if (O_PIX_DATA !== 16'd0) begin n_fail++; $display("FAIL reset_pix_data: got %h, required 0000", O_PIX_DATA); end
        n_checks++; if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", O_BUSY); end
        n_checks++; if (O_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", O_DONE); end
        repeat (2) @(negedge I_CLK);
        I_RST_N = 1'b1;
        @(posedge I_CLK); #1;
        n_checks++; if (O_CMD_READY !== 1'b1 || O_BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got ready=%b busy=%b, required ready=1 busy=0", O_CMD_READY, O_BUSY); end
    endtask

    task automatic test_horizontal;
        int a, d;
        send_cmd(10'd0, 10'd0, 10'd3, 10'd0, 16'hF00F, 1'b0, a);
        for (int k = 0; k < 4; k++) exp_q.push_back('{k, 16'hF00F, a + 2 + k});
        wait_done(d);
        n_checks++; if (d != a + 6) begin n_fail++; $display("FAIL horiz_done_cycle: got %0d, required %0d", d, a + 6); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL horiz_missing: got %0d pixels outstanding, required 0", exp_q.size()); end
        repeat (3) @(negedge I_CLK);
        n_checks++; if (done_q.size() != 0) begin n_fail++; $display("FAIL horiz_done_single: got %0d extra pulses, required 0", done_q.size()); end
    endtask

    task automatic test_point;
        int a, d, cnt;
        cnt = 0;
        send_cmd(10'd5, 10'd5, 10'd5, 10'd5, 16'h1234, 1'b0, a);
        exp_q.push_back('{3205, 16'h1234, a + 2});
        for (int i = 0; i < 20; i++) begin
            @(negedge I_CLK);
            if (O_BUSY) cnt++;
            else if (cnt > 0) break;
        end
        wait_done(d);
        n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL point_busy_cycles: got %0d, required 4", cnt); end
        n_checks++; if (d != a + 3) begin n_fail++; $display("FAIL point_done_cycle: got %0d, required %0d", d, a + 3); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL point_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_steep;
        int a, d;
        int addrs[5] = '{2562, 1921, 1281, 640, 0};
        send_cmd(10'd2, 10'd4, 10'd0, 10'd0, 16'hABCD, 1'b0, a);
        for (int k = 0; k < 5; k++) exp_q.push_back('{addrs[k], 16'hABCD, a + 2 + k});
        wait_done(d);
        n_checks++; if (d != a + 7) begin n_fail++; $display("FAIL steep_done_cycle: got %0d, required %0d", d, a + 7); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL steep_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        int a, d;
        send_cmd(10'd10, 10'd0, 10'd12, 10'd0, 16'h5A5A, 1'b0, a);
        exp_q.push_back('{10, 16'h5A5A, a + 2});
        exp_q.push_back('{11, 16'h5A5A, a + 6});
        exp_q.push_back('{12, 16'h5A5A, a + 7});
        wait_cyc(a + 3);
        I_PIX_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge I_CLK);
            n_checks++;
            if (O_PIX_VALID !== 1'b1 || O_PIX_ADDR !== 18'd11 || O_PIX_DATA !== 16'h5A5A) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b addr=%0d data=%h, required valid=1 addr=11 data=5a5a",
                         i, O_PIX_VALID, O_PIX_ADDR, O_PIX_DATA);
            end
        end
        @(posedge I_CLK); #1;
        I_PIX_READY = 1'b1;
        wait_done(d);
        n_checks++; if (d != a + 8) begin n_fail++; $display("FAIL bp_done_cycle: got %0d, required %0d", d, a + 8); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_clip;
        int a, d;
        send_cmd(10'd638, 10'd0, 10'd641, 10'd0, 16'h0F0F, 1'b0, a);
        exp_q.push_back('{638, 16'h0F0F, a + 2});
        exp_q.push_back('{639, 16'h0F0F, a + 3});
        wait_done(d);
        n_checks++; if (d != a + 6) begin n_fail++; $display("FAIL clip_done_cycle: got %0d, required %0d", d, a + 6); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int a1, d1, d2;
        int l1[4] = '{0, 1, 642, 643};
        int l2[4] = '{6420, 6419, 6418, 6417};
        send_cmd(10'd0, 10'd0, 10'd3, 10'd1, 16'h1111, 1'b1, a1);
        // Second command sits on the bus while the first draws; it must not disturb line 1
        I_X0 = 10'd20; I_Y0 = 10'd10; I_X1 = 10'd17; I_Y1 = 10'd10; I_COLOR = 16'h2222;
        for (int k = 0; k < 4; k++) exp_q.push_back('{l1[k], 16'h1111, a1 + 2 + k});
        for (int k = 0; k < 4; k++) exp_q.push_back('{l2[k], 16'h2222, a1 + 10 + k});
        wait_cyc(a1 + 8);
        I_CMD_VALID = 1'b0;
        wait_done(d1);
        wait_done(d2);
        n_checks++; if (d1 != a1 + 6) begin n_fail++; $display("FAIL b2b_done1_cycle: got %0d, required %0d", d1, a1 + 6); end
        n_checks++; if (d2 != a1 + 14) begin n_fail++; $display("FAIL b2b_done2_cycle: got %0d, required %0d", d2, a1 + 14); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midline;
        int a, d;
        send_cmd(10'd0, 10'd0, 10'd9, 10'd9, 16'h7777, 1'b0, a);
        for (int k = 0; k < 10; k++) exp_q.push_back('{k * 641, 16'h7777, a + 2 + k});
        wait_cyc(a + 4);
        #1 I_RST_N = 1'b0;
        #1;
        n_checks++;
        if (O_CMD_READY !== 1'b1 || O_PIX_VALID !== 1'b0 || O_PIX_ADDR !== 18'd0 ||
            O_PIX_DATA !== 16'd0 || O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b addr=%0d data=%h busy=%b done=%b, required 1 0 0 0000 0 0",
                     O_CMD_READY, O_PIX_VALID, O_PIX_ADDR, O_PIX_DATA, O_BUSY, O_DONE);
        end
        n_checks++; if (exp_q.size() != 8) begin n_fail++; $display("FAIL midreset_transfers: got %0d outstanding, required 8", exp_q.size()); end
        exp_q.delete();
        repeat (2) @(negedge I_CLK);
        I_RST_N = 1'b1;
        repeat (3) @(negedge I_CLK);
        n_checks++; if (done_q.size() != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses, required 0", done_q.size()); end
        send_cmd(10'd4, 10'd2, 10'd6, 10'd2, 16'h4242, 1'b0, a);
        for (int k = 0; k < 3; k++) exp_q.push_back('{1284 + k, 16'h4242, a + 2 + k});
        wait_done(d);
        n_checks++; if (d != a + 5) begin n_fail++; $display("FAIL postreset_done_cycle: got %0d, required %0d", d, a + 5); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL postreset_missing: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_horizontal;
        test_point;
        test_steep;
        test_backpressure;
        test_clip;
        test_back_to_back;
        test_reset_midline;
        repeat (3) @(negedge I_CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
